// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encodings,
// instruction field positions and a small opcode-extraction helper.
package alu_pkg;

  localparam int INSTR_W  = 8;
  localparam int OPCODE_W = 3;
  localparam int STATE_W  = 3;

  typedef logic [STATE_W-1:0] state_t;

  // FSM state encodings
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DECODE   = 3'd1;
  localparam state_t ST_EXEC     = 3'd2;
  localparam state_t ST_WAIT_ALU = 3'd3;
  localparam state_t ST_WB       = 3'd4;
  localparam state_t ST_WAIT_WB  = 3'd5;

  // Instruction field positions
  localparam int OP_MSB    = 7;
  localparam int OP_LSB    = 5;
  localparam int DST_BIT   = 4;
  localparam int SRC_A_BIT = 3;
  localparam int SRC_B_BIT = 2;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction at a time, drives the register
// bank operand read, starts the ALU, issues the write-back and counts
// completed instructions.
// Optional feature macro: ALU_TIMEOUT_EN (bounded wait for alu_done with
// a sticky err flag; when undefined err is tied low and the wait is unbounded).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [INSTR_W-1:0]  bank_instr,
  output logic                bank_init,
  output logic                bank_rd,
  input  logic                bank_done,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                alu_init,
  input  logic                alu_done,
  output logic                busy,
  output logic                err,
  output logic [7:0]          op_count
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       timeout_hit;

`ifdef ALU_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // The wait is abandoned in the last allowed WAIT_ALU cycle if the ALU is still silent
  assign timeout_hit = (state == ST_WAIT_ALU) && !alu_done && (wait_cnt == TW'(TIMEOUT - 1));

  // Count cycles spent in WAIT_ALU; restart from zero whenever outside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_ALU) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag, only cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Main sequencing FSM with instruction latch, read-latency counter and op counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bank_instr <= '0;
      lat_cnt    <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            bank_instr <= instr_in;
            lat_cnt    <= LAT_INIT;
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (lat_cnt == 3'd1) begin
            state <= ST_EXEC;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_EXEC: begin
          state <= alu_done ? ST_WB : ST_WAIT_ALU;
        end
        ST_WAIT_ALU: begin
          if (alu_done) begin
            state <= ST_WB;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_WB: begin
          state <= ST_WAIT_WB;
        end
        ST_WAIT_WB: begin
          if (bank_done) begin
            op_count <= op_count + 8'd1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and status are decoded purely from the current state
  always_comb begin
    instr_ready = 1'b0;
    bank_init   = 1'b0;
    alu_init    = 1'b0;
    bank_rd     = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_DECODE: bank_init = 1'b1;
      ST_EXEC:   alu_init  = 1'b1;
      ST_WB:     bank_rd   = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = get_opcode(bank_instr);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard testbench for alu_sequencer with directed instruction vectors.
// Stimulus pushes each expected instruction into a queue; a monitor pops
// and compares on every write-back strobe. Honors ALU_TIMEOUT_EN.
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] bank_instr;
  logic       bank_init;
  logic       bank_rd;
  logic       bank_done;
  logic [2:0] alu_op;
  logic       alu_init;
  logic       alu_done;
  logic       busy;
  logic       err;
  logic [7:0] op_count;

  int checks   = 0;
  int failures = 0;
  int rd_total = 0;
  int init_cnt = 0;
  int pulse_cnt = 0;
  logic alu_auto  = 1'b1;
  logic bank_auto = 1'b1;
  logic [7:0] exp_q[$];

  alu_sequencer #(.READ_LAT(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .bank_instr(bank_instr), .bank_init(bank_init),
    .bank_rd(bank_rd), .bank_done(bank_done), .alu_op(alu_op), .alu_init(alu_init),
    .alu_done(alu_done), .busy(busy), .err(err), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ins);
    int guard = 0;
    @(negedge clk);
    instr_in    = ins;
    instr_valid = 1'b1;
    while (!instr_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_bound", guard < 200, 1);
    exp_q.push_back(ins);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (instr_ready || cycles >= 200) break;
      cycles++;
    end
    checkOutput("idle_bound", cycles < 200, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Models the ALU and register bank: each answers one cycle after its strobe
  initial begin
    logic a, b;
    alu_done  = 1'b0;
    bank_done = 1'b0;
    forever begin
      @(negedge clk);
      a = alu_init;
      b = bank_rd;
      @(posedge clk);
      #1;
      if (alu_auto)  alu_done  = a;
      if (bank_auto) bank_done = b;
    end
  end

  // Monitor: counts strobes per operation and checks each write-back against the queue
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset || !busy) begin
        init_cnt  = 0;
        pulse_cnt = 0;
      end else begin
        if (bank_init) init_cnt++;
        if (alu_init)  pulse_cnt++;
        if (bank_rd) begin
          rd_total++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_bank_rd", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("wb_bank_instr", bank_instr, e);
            checkOutput("wb_alu_op", alu_op, e[7:5]);
            checkOutput("wb_bank_init_cycles", init_cnt, 2);
            checkOutput("wb_alu_init_pulses", pulse_cnt, 1);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int rd_before;
    int guard;
    int cnt;
    reset       = 1'b0;
    instr_in    = 8'h00;
    instr_valid = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_bank_instr", bank_instr, 0);
    checkOutput("rst_bank_init", bank_init, 0);
    checkOutput("rst_bank_rd", bank_rd, 0);
    checkOutput("rst_alu_init", alu_init, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_op_count", op_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_instr_ready", instr_ready, 1);

    // Single instruction, best-case latency READ_LAT+4
    applyStimulus(8'h1C);
    waitIdle(lat);
    checkOutput("single_latency", lat, 6);
    checkOutput("single_op_count", op_count, 1);
    checkOutput("single_rd_total", rd_total, 1);

    // Valid held during a busy operation: second instruction waits for IDLE
    @(negedge clk);
    instr_in    = 8'h1C;
    instr_valid = 1'b1;
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'hC0);
    @(posedge clk);
    #1 instr_in = 8'hC0;
    @(negedge clk);
    checkOutput("held_ready_low", instr_ready, 0);
    checkOutput("held_bank_instr", bank_instr, 8'h1C);
    waitIdle(lat);
    checkOutput("held_first_latency", lat, 5);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    waitIdle(lat);
    checkOutput("held_op_count", op_count, 3);
    checkOutput("held_rd_total", rd_total, 3);

    // Spurious alu_done/bank_done in IDLE, alu_done in DECODE, alu_done in EXEC
    alu_auto  = 1'b0;
    bank_auto = 1'b0;
    rd_before = rd_total;
    alu_done  = 1'b1;
    bank_done = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_ignore_busy", busy, 0);
    checkOutput("idle_ignore_rd", rd_total, rd_before);
    checkOutput("idle_ignore_count", op_count, 3);
    bank_done   = 1'b0;
    bank_auto   = 1'b1;
    instr_in    = 8'h64;
    instr_valid = 1'b1;
    exp_q.push_back(8'h64);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("decode_ignore_1", bank_init, 1);
    @(negedge clk);
    checkOutput("decode_ignore_2", bank_init, 1);
    checkOutput("decode_no_rd", bank_rd, 0);
    alu_done = 1'b0;
    @(negedge clk);
    checkOutput("exec_alu_init", alu_init, 1);
    alu_done = 1'b1;
    @(posedge clk);
    #1 alu_done = 1'b0;
    @(negedge clk);
    checkOutput("exec_done_to_wb", bank_rd, 1);
    alu_auto = 1'b1;
    waitIdle(lat);
    checkOutput("exec_op_count", op_count, 4);

    // Reset asserted while waiting for the ALU
    alu_auto = 1'b0;
    rd_before = rd_total;
    applyStimulus(8'hA8);
    guard = 0;
    while (guard < 50) begin
      @(negedge clk);
      if (alu_init) break;
      guard++;
    end
    checkOutput("midrst_reach_exec", guard < 50, 1);
    @(negedge clk);
    checkOutput("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", instr_ready, 1);
    checkOutput("midrst_bank_instr", bank_instr, 0);
    checkOutput("midrst_op_count", op_count, 0);
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    bank_auto = 1'b0;
    alu_done  = 1'b1;
    bank_done = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_rd", rd_total, rd_before);
    checkOutput("midrst_idle", busy, 0);
    checkOutput("midrst_count_kept", op_count, 0);
    alu_done  = 1'b0;
    bank_done = 1'b0;
    alu_auto  = 1'b1;
    bank_auto = 1'b1;

`ifdef ALU_TIMEOUT_EN
    // ALU never answers: timeout after 15 WAIT_ALU cycles
    alu_auto = 1'b0;
    rd_before = rd_total;
    applyStimulus(8'h2C);
    guard = 0;
    while (guard < 50) begin
      @(negedge clk);
      if (alu_init) break;
      guard++;
    end
    checkOutput("to_reach_exec", guard < 50, 1);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cnt >= 100) break;
      cnt++;
    end
    checkOutput("to_wait_cycles", cnt, 15);
    checkOutput("to_err", err, 1);
    checkOutput("to_no_rd", rd_total, rd_before);
    checkOutput("to_op_count", op_count, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    alu_auto = 1'b1;
    applyStimulus(8'h1C);
    waitIdle(lat);
    checkOutput("to_err_sticky", err, 1);
    checkOutput("to_next_count", op_count, 1);
    doReset();
    checkOutput("to_err_cleared", err, 0);
`else
    checkOutput("err_tied_low", err, 0);
    doReset();
`endif

    // 256 back-to-back instructions wrap op_count
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i));
      waitIdle(lat);
      if (i == 254) checkOutput("wrap_255", op_count, 255);
    end
    checkOutput("wrap_0", op_count, 0);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter READ_LAT, default 2, cycles bank_init held high before the ALU starts (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for alu_done (used only with ALU_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_in  input  8  instruction; [7:5] opcode, [4] destination, [3] operand A, [2] operand B.
REQ-006 SHALL have port instr_valid  input  1  instruction offered.
REQ-007 SHALL have port instr_ready  output  1  sequencer can accept an instruction.
REQ-008 SHALL have port bank_instr  output  8  registered copy of the accepted instruction, driven to the register bank.
REQ-009 SHALL have port bank_init  output  1  register bank decode/operand-read enable.
REQ-010 SHALL have port bank_rd  output  1  register bank write-back strobe.
REQ-011 SHALL have port bank_done  input  1  register bank write-back complete.
REQ-012 SHALL have port alu_op  output  3  opcode to the ALU, equal to bank_instr[7:5].
REQ-013 SHALL have port alu_init  output  1  one-cycle ALU start pulse.
REQ-014 SHALL have port alu_done  input  1  ALU result valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port err  output  1  sticky timeout flag.
REQ-017 SHALL have port op_count  output  8  count of completed instructions.

Function
REQ-018 SHALL implement states IDLE, DECODE, EXEC, WAIT_ALU, WB, WAIT_WB.
REQ-019 IDLE: instr_ready=1; on instr_valid&instr_ready SHALL latch instr_in into bank_instr and go to DECODE.
REQ-020 DECODE: bank_init=1 for exactly READ_LAT cycles (down-counter), then go to EXEC.
REQ-021 EXEC: alu_init=1 for exactly one cycle, then go to WAIT_ALU.
REQ-022 WAIT_ALU: hold until alu_done=1, then go to WB; alu_done in the EXEC cycle SHALL also be accepted (go straight to WB).
REQ-023 WB: bank_rd=1 for exactly one cycle, then go to WAIT_WB.
REQ-024 WAIT_WB: on bank_done=1 SHALL increment op_count (mod 256, 255->0) and return to IDLE.
REQ-025 instr_ready SHALL be 0 outside IDLE; instr_valid outside IDLE SHALL be ignored, not queued.
REQ-026 alu_done or bank_done outside their wait states SHALL be ignored.
REQ-027 Best-case latency accept->instr_ready high again: READ_LAT+4 cycles with alu_done and bank_done each one cycle after their strobes.
REQ-028 bank_instr SHALL stay stable from acceptance until return to IDLE.

Reset
REQ-029 reset=0 SHALL immediately force IDLE from any state, including mid-operation, with no write-back issued.
REQ-030 Reset values: bank_instr=0, bank_init=0, bank_rd=0, alu_init=0, alu_op=0, busy=0, err=0, op_count=0, instr_ready=1 once reset deasserts.

Configuration
REQ-031 Macro ALU_TIMEOUT_EN compiled in: WAIT_ALU counts cycles; after TIMEOUT cycles without alu_done SHALL set err=1 (sticky until reset), skip WB, return to IDLE without incrementing op_count.
REQ-032 Without ALU_TIMEOUT_EN: err SHALL be tied 0 and WAIT_ALU waits indefinitely.

Structure
REQ-033 State encodings, opcode field positions and instruction bit indices SHALL live in shared package alu_pkg.
REQ-034 The design SHALL be one module; no sub-module required.

Verification
REQ-035 reset released, instr_in=8'h1C (op 0, dst 1, A 1, B 1) valid one cycle, alu_done/bank_done one cycle after strobes -> bank_init high 2 cycles, one alu_init pulse, one bank_rd pulse, op_count=1, instr_ready high 6 cycles after acceptance.
REQ-036 instr_valid held high during a busy operation with instr_in=8'hC0 -> second instruction accepted only on return to IDLE; op_count reaches 2.
REQ-037 reset=0 asserted in WAIT_ALU -> next edge in IDLE, bank_rd never pulses, op_count unchanged at 0.
REQ-038 256 back-to-back instructions -> op_count wraps to 0.
REQ-039 With ALU_TIMEOUT_EN, TIMEOUT=15, alu_done never asserted -> err=1 after 15 WAIT_ALU cycles, no bank_rd, return to IDLE; err stays 1 until reset.
REQ-040 alu_done asserted in IDLE and during DECODE -> no state change, no bank_rd.
